// File: rtl/ps2_receptor_teclado.sv
// rtl/ps2_receptor_teclado.sv - PS/2 keyboard receiver that turns command-key make codes into control tokens.
module ps2_receptor_teclado #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] datotec_o,
  output logic       valid_o,
  output logic       err_o
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DATA   = 3'd1;
  localparam logic [2:0] S_PARITY = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_DECODE = 3'd4;

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;
  logic          data_s;

  logic [2:0]    state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          par_q, par_d;
  logic          ok_q, ok_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    dat_q, dat_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [7:0]    tok;

  assign data_s = data_sync_q[1];

  // Filtered clock flips only after FILTER_LEN consecutive opposite samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == FLT_MAX) begin
        filt_d = ~filt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  assign fall = filt_q & ~filt_d;

  always_comb begin
    tok = 8'hFF;
    case (shift_q)
      8'h43:   tok = 8'h80;
      8'h32:   tok = 8'hC1;
      8'h1C:   tok = 8'h88;
      8'h21:   tok = 8'hC6;
      8'h23:   tok = 8'hA1;
      8'h5A:   tok = 8'hFE;
      default: tok = 8'hFF;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    ok_d      = ok_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    tmo_d     = (state_q == S_IDLE) ? '0 : tmo_q + 1'b1;
    dat_d     = 8'hFF;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fall && !data_s) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_d   = data_s;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          ok_d    = data_s & ((^shift_q) ^ par_q);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_IDLE;
        if (!ok_q) begin
          err_d = 1'b1;
        end else if (shift_q == 8'hF0) begin
          brk_d = 1'b1;
        end else if (shift_q == 8'hE0) begin
          ext_d = 1'b1;
        end else if (brk_q) begin
          brk_d = 1'b0;
          ext_d = 1'b0;
        end else begin
          ext_d = 1'b0;
          if (tok != 8'hFF) begin
            dat_d   = tok;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled keyboard clock aborts the frame and forgets any prefix.
    if (state_q != S_IDLE && state_q != S_DECODE) begin
      if (fall) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_MAX) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        brk_d   = 1'b0;
        ext_d   = 1'b0;
        tmo_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      fcnt_q      <= '0;
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      par_q       <= 1'b0;
      ok_q        <= 1'b0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      tmo_q       <= '0;
      dat_q       <= 8'hFF;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      par_q       <= par_d;
      ok_q        <= ok_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      tmo_q       <= tmo_d;
      dat_q       <= dat_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign datotec_o = dat_q;
  assign valid_o   = valid_q;
  assign err_o     = err_q;

endmodule

// File: doc/ps2_receptor_teclado.md
Name: ps2_receptor_teclado

Overview:
- PS/2 keyboard receiver. Deserializes device-to-host frames from the keyboard and filters out break and unmapped codes.
- Translates the six command keys into the 8-bit key tokens consumed by the keyboard-driven control state machine on datotec_o.
- Sits between the board PS/2 pins and that state machine. All outputs are in the clk_i domain.

Parameters:
- FILTER_LEN, 8: number of consecutive identical clk_i samples of ps2_clk needed to change its filtered level.
- TIMEOUT_CYC, 50000: clk_i cycles allowed between filtered ps2_clk falling edges inside a frame before the frame is aborted.

Ports:
- clk_i  input  1  system clock; all logic on its rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- ps2_clk_i  input  1  raw PS/2 clock from keyboard, asynchronous.
- ps2_data_i  input  1  raw PS/2 data from keyboard, asynchronous.
- datotec_o  output  8  key token. 8'hFF when idle; valid token for exactly one cycle.
- valid_o  output  1  one-cycle strobe, coincident with a non-FF datotec_o.
- err_o  output  1  one-cycle strobe on a framing, parity or timeout error.

Behaviour:
- Reset (rst_i=0, async):
  - datotec_o=8'hFF, valid_o=0, err_o=0.
  - FSM=IDLE, shift register, bit counter, timeout counter, brk and ext flags all cleared.
  - Filtered ps2_clk level=1.
  - Reset mid-frame discards the partial frame with no output.
- Input conditioning:
  - Both PS/2 inputs pass through 2-FF synchronizers.
  - Filtered ps2_clk flips only after FILTER_LEN consecutive synchronized samples at the opposite level.
  - A fall event is a 1-cycle pulse on a filtered 1->0 transition. ps2_data (synchronized) is sampled in that cycle.
- Frame format: start=0, 8 data bits LSB first, odd parity, stop=1.
- FSM states: IDLE, DATA, PARITY, STOP, DECODE.
  - IDLE: on fall with data=0 -> DATA, bit counter=0. Fall with data=1 is ignored and the FSM stays IDLE.
  - DATA: on each fall, shift the data bit into bit [7] (right shift). After the 8th bit -> PARITY.
  - PARITY: on fall, store the parity bit -> STOP.
  - STOP: on fall, check the frame.
    - If stop=1 and XOR(data, parity)=1 -> DECODE.
    - Otherwise pulse err_o for 1 cycle -> IDLE. brk and ext are unchanged.
  - DECODE: one cycle, then -> IDLE.
    - Byte F0: set brk, no output.
    - Byte E0: set ext, no output.
    - Other byte with brk=1: clear brk and ext, no output (key release).
    - Other byte with brk=0: look up the token, clear ext.
- Timeout:
  - The counter clears on every fall and increments every cycle while the FSM is not IDLE.
  - On reaching TIMEOUT_CYC-1: pulse err_o, go to IDLE, discard the partial frame, clear brk and ext.
- Token map (scan code -> datotec_o), any ext state unless noted:
  - 43 (I) -> 80
  - 32 (B) -> C1
  - 1C (A) -> 88
  - 21 (C) -> C6
  - 23 (D) -> A1
  - 5A (Enter, ext=0 or 1) -> FE
  - All other codes -> no output (datotec_o stays FF, valid_o=0).
- Output timing:
  - datotec_o and valid_o are registered.
  - The token appears exactly 2 clk_i cycles after the fall-pulse cycle of the stop bit, is held 1 cycle, then returns to FF.
  - err_o follows the same latency relative to the stop fall; for timeout, it is 1 cycle after the counter hits its limit.
- Simultaneous events: a fall arriving during DECODE is ignored. A keyboard cannot legally produce this; no error is raised.
- Typematic repeats (repeated make codes) each produce a token.

Test Plan:
- Reset, then idle lines high for 1000 cycles -> datotec_o=FF, valid_o=0, err_o=0 throughout.
- Frame 0x43, parity 0 (FILTER_LEN=8, 20-cycle half periods) -> datotec_o=80 and valid_o=1 for exactly one cycle, 2 cycles after the stop fall; then FF.
- Sequence F0,43 then 5A -> no token for F0 or 43; then datotec_o=FE for one cycle. Repeat with E0,5A -> FE.
- Frame 0x1C with wrong parity, then frame 0x1C with stop=0 -> err_o pulses twice, no valid_o; a following good 0x1C -> 88.
- Stall ps2_clk high after 4 data bits with TIMEOUT_CYC=200 -> err_o pulse 200 cycles after the last fall, FSM IDLE; the next good 0x21 frame -> C6.
- 3-cycle low glitch on ps2_clk in IDLE -> no state change. Unmapped code 0x15 -> no valid_o, no err_o. rst_i low mid-frame -> outputs at reset values, and the next full frame decodes correctly.
